hm_time_setter: RTL and testbench

- Write side of the hour/minute display path. Owns the BCD hour and minute registers that the display selector reads.
- sel routes edit operations (increment/decrement, with auto-repeat) to exactly one register: the hour or the minute.
- Also advances the time on a minute tick and accepts a parallel preset load.
- Sits between the top-level FSM/button conditioning and the display multiplexer.

---
 rtl/hm_time_setter_pkg.sv | 8 +
 rtl/bcd_wrap_step.sv | 16 +
 rtl/hm_time_setter.sv | 129 ++++++++++++
 tb/tb_hm_time_setter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hm_time_setter_pkg.sv
// hm_time_setter_pkg: shared select encoding, BCD limits and edit FSM states
package hm_time_setter_pkg;
    localparam logic SEL_HOUR = 1'b0;
    localparam logic SEL_MIN  = 1'b1;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
endpackage

// File: rtl/bcd_wrap_step.sv
// bcd_wrap_step: one BCD up/down step on a two-digit value wrapping between 00 and max
module bcd_wrap_step (
    input  logic [7:0] value,
    input  logic [7:0] max,
    input  logic       up,
    output logic [7:0] next,
    output logic       wrap
);
    // wrap at the range ends, otherwise carry or borrow between the BCD digits
    always_comb begin
        wrap = up ? (value == max) : (value == 8'h00);
        next = wrap ? (up ? 8'h00 : max) :
               up   ? ((value[3:0] == 4'd9) ? {value[7:4] + 4'd1, 4'd0} : {value[7:4], value[3:0] + 4'd1}) :
                      ((value[3:0] == 4'd0) ? {value[7:4] - 4'd1, 4'd9} : {value[7:4], value[3:0] - 4'd1});
    end
endmodule

// File: rtl/hm_time_setter.sv
// hm_time_setter: BCD hour/minute registers with button edit, auto-repeat, minute tick and preset load
module hm_time_setter
    import hm_time_setter_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       inc,
    input  logic       dec,
    input  logic       tick_min,
    input  logic       load_en,
    input  logic [7:0] load_h,
    input  logic [7:0] load_m,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic       editing,
    output logic       load_err
);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d, dir_q, dir_d;
    logic [7:0]       hour_q, hour_d, minute_q, minute_d;
    logic             editing_q, editing_d, load_err_q, load_err_d;
    logic             step, step_up, tick_ok, leave, load_ok, h_up;
    logic [7:0]       h_next, m_edit_next, m_tick_next;
    logic             m_tick_wrap;
    logic [1:0]       unused_wraps;

    assign load_ok = (load_h[7:4] <= 4'd9) && (load_h[3:0] <= 4'd9) && (load_h <= HOUR_MAX) &&
                     (load_m[7:4] <= 4'd9) && (load_m[3:0] <= 4'd9) && (load_m <= MIN_MAX);
    assign h_up = step ? step_up : 1'b1;

    bcd_wrap_step u_hour     (.value(hour_q),   .max(HOUR_MAX), .up(h_up),    .next(h_next),      .wrap(unused_wraps[0]));
    bcd_wrap_step u_min_edit (.value(minute_q), .max(MIN_MAX),  .up(step_up), .next(m_edit_next), .wrap(unused_wraps[1]));
    bcd_wrap_step u_min_tick (.value(minute_q), .max(MIN_MAX),  .up(1'b1),    .next(m_tick_next), .wrap(m_tick_wrap));

    // edit FSM: first step on press, delayed auto-repeat, abort on any button/select disturbance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        step    = 1'b0;
        step_up = dir_q;
        tick_ok = 1'b0;
        leave   = (dir_q ? (!inc || dec) : (!dec || inc)) || (sel != sel_q);
        if (load_en) begin
            if (load_ok) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (state_q == IDLE) begin
            if (inc ^ dec) begin
                step    = 1'b1;
                step_up = inc;
                dir_d   = inc;
                sel_d   = sel;
                state_d = HOLD;
                cnt_d   = '0;
            end else begin
                tick_ok = tick_min;
            end
        end else if (leave) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (cnt_q == ((state_q == HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
            step    = 1'b1;
            state_d = REPEAT;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // time registers: preset beats edit step, which beats the minute tick
    always_comb begin
        hour_d     = hour_q;
        minute_d   = minute_q;
        load_err_d = load_en && !load_ok;
        editing_d  = (state_d != IDLE);
        if (load_en) begin
            if (load_ok) begin
                hour_d   = load_h;
                minute_d = load_m;
            end
        end else if (step) begin
            if (sel == SEL_MIN) minute_d = m_edit_next;
            else hour_d = h_next;
        end else if (tick_ok) begin
            minute_d = m_tick_next;
            hour_d   = m_tick_wrap ? h_next : hour_q;
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= SEL_HOUR;
            dir_q      <= 1'b0;
            hour_q     <= 8'h00;
            minute_q   <= 8'h00;
            editing_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            dir_q      <= dir_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            editing_q  <= editing_d;
            load_err_q <= load_err_d;
        end
    end

    assign hour     = hour_q;
    assign minute   = minute_q;
    assign editing  = editing_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_hm_time_setter.sv
// tb_hm_time_setter: directed and randomized checks against an integer-time reference model
module tb_hm_time_setter;
    localparam int RD = 4;
    localparam int RP = 2;

    logic       clk = 1'b0;
    logic       rst, sel, inc, dec, tick_min, load_en;
    logic [7:0] load_h, load_m;
    logic [7:0] hour, minute;
    logic       editing, load_err;

    int checks = 0;
    int errors = 0;

    int mh = 0, mm = 0, m_age = 0;
    bit m_act = 0, m_dir = 0, m_sel = 0, m_err = 0;

    hm_time_setter #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .inc(inc), .dec(dec), .tick_min(tick_min),
        .load_en(load_en), .load_h(load_h), .load_m(load_m),
        .hour(hour), .minute(minute), .editing(editing), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic bit valid(input logic [7:0] b, input int lim);
        int t, u;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        return t <= 9 && u <= 9 && t * 10 + u <= lim;
    endfunction

    function automatic void edit(input bit up, input bit s);
        if (s) mm = up ? (mm + 1) % 60 : (mm + 59) % 60;
        else   mh = up ? (mh + 1) % 24 : (mh + 23) % 24;
    endfunction

    // advance the model with the current inputs, then clock the DUT
    task automatic cycle();
        m_err = 0;
        if (rst) begin
            mh = 0; mm = 0; m_act = 0;
        end else if (load_en) begin
            if (valid(load_h, 23) && valid(load_m, 59)) begin
                mh = int'(load_h[7:4]) * 10 + int'(load_h[3:0]);
                mm = int'(load_m[7:4]) * 10 + int'(load_m[3:0]);
                m_act = 0;
            end else m_err = 1;
        end else if (!m_act) begin
            if (inc != dec) begin
                edit(inc, sel);
                m_act = 1; m_age = 0; m_dir = inc; m_sel = sel;
            end else if (tick_min) begin
                mm = (mm + 1) % 60;
                if (mm == 0) mh = (mh + 1) % 24;
            end
        end else if ((m_dir ? !inc : !dec) || (inc && dec) || sel != m_sel) begin
            m_act = 0;
        end else begin
            m_age++;
            if (m_age >= RD && (m_age - RD) % RP == 0) edit(m_dir, m_sel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; sel = 0; inc = 0; dec = 0; tick_min = 0; load_en = 0; load_h = 0; load_m = 0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m);
        load_en = 1; load_h = h; load_m = m;
        cycle();
        load_en = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) cycle();
        rst = 0;
        repeat (10) cycle();
        checks++; if (hour !== 8'h00) begin errors++; $display("FAIL reset_hour got %h want 00", hour); end
        checks++; if (minute !== 8'h00) begin errors++; $display("FAIL reset_minute got %h want 00", minute); end
        checks++; if (editing !== 1'b0) begin errors++; $display("FAIL reset_editing got %b want 0", editing); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b want 0", load_err); end
    endtask

    task automatic test_hour_wrap();
        do_load(8'h23, 8'h10);
        sel = 0; inc = 1;
        cycle();
        inc = 0;
        checks++; if (hour !== 8'h00 || minute !== 8'h10) begin errors++; $display("FAIL hour_inc_wrap got %h:%h want 00:10", hour, minute); end
        cycle();
        dec = 1;
        cycle();
        dec = 0;
        checks++; if (hour !== 8'h23 || minute !== 8'h10) begin errors++; $display("FAIL hour_dec_wrap got %h:%h want 23:10", hour, minute); end
        cycle();
    endtask

    task automatic test_auto_repeat();
        int n;
        int steps[5] = '{1, 5, 7, 9, 11};
        do_load(8'h05, 8'h57);
        sel = 1; inc = 1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            n = 0;
            foreach (steps[i]) if (steps[i] <= k) n++;
            checks++;
            if (minute !== bcd((57 + n) % 60) || hour !== 8'h05 || editing !== 1'b1) begin
                errors++;
                $display("FAIL auto_repeat cyc %0d got %h:%h ed=%b want 05:%h ed=1", k, hour, minute, editing, bcd((57 + n) % 60));
            end
        end
        inc = 0;
        cycle();
        checks++; if (editing !== 1'b0 || minute !== 8'h02) begin errors++; $display("FAIL repeat_release got %h ed=%b want 02 ed=0", minute, editing); end
    endtask

    task automatic test_tick();
        do_load(8'h23, 8'h59);
        tick_min = 1;
        cycle();
        tick_min = 0;
        checks++; if (hour !== 8'h00 || minute !== 8'h00) begin errors++; $display("FAIL tick_rollover got %h:%h want 00:00", hour, minute); end
        sel = 1; inc = 1;
        cycle();
        tick_min = 1;
        cycle();
        tick_min = 0;
        checks++; if (hour !== 8'h00 || minute !== 8'h01 || editing !== 1'b1) begin errors++; $display("FAIL tick_while_editing got %h:%h ed=%b want 00:01 ed=1", hour, minute, editing); end
        inc = 0;
        cycle();
    endtask

    task automatic test_load();
        do_load(8'h24, 8'h00);
        checks++; if (hour !== 8'h00 || minute !== 8'h01 || load_err !== 1'b1) begin errors++; $display("FAIL bad_hour_load got %h:%h err=%b want 00:01 err=1", hour, minute, load_err); end
        cycle();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_width got %b want 0", load_err); end
        do_load(8'h12, 8'h5A);
        checks++; if (hour !== 8'h00 || minute !== 8'h01 || load_err !== 1'b1) begin errors++; $display("FAIL bad_min_load got %h:%h err=%b want 00:01 err=1", hour, minute, load_err); end
        sel = 1; inc = 1;
        repeat (RD + 2) cycle();
        inc = 0;
        do_load(8'h12, 8'h34);
        checks++; if (hour !== 8'h12 || minute !== 8'h34 || editing !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL load_in_repeat got %h:%h ed=%b err=%b want 12:34 ed=0 err=0", hour, minute, editing, load_err); end
    endtask

    task automatic test_conflicts();
        inc = 1; dec = 1;
        cycle();
        cycle();
        inc = 0; dec = 0;
        checks++; if (hour !== 8'h12 || minute !== 8'h34 || editing !== 1'b0) begin errors++; $display("FAIL both_buttons got %h:%h ed=%b want 12:34 ed=0", hour, minute, editing); end
        sel = 0; inc = 1;
        cycle();
        checks++; if (hour !== 8'h13 || editing !== 1'b1) begin errors++; $display("FAIL sel_first_step got %h ed=%b want 13 ed=1", hour, editing); end
        sel = 1;
        cycle();
        checks++; if (hour !== 8'h13 || minute !== 8'h34 || editing !== 1'b0) begin errors++; $display("FAIL sel_change_exit got %h:%h ed=%b want 13:34 ed=0", hour, minute, editing); end
        cycle();
        checks++; if (hour !== 8'h13 || minute !== 8'h35 || editing !== 1'b1) begin errors++; $display("FAIL sel_new_target got %h:%h ed=%b want 13:35 ed=1", hour, minute, editing); end
        repeat (RD + 2) cycle();
        rst = 1;
        cycle();
        rst = 0; inc = 0;
        checks++; if (hour !== 8'h00 || minute !== 8'h00 || editing !== 1'b0) begin errors++; $display("FAIL rst_in_repeat got %h:%h ed=%b want 00:00 ed=0", hour, minute, editing); end
        cycle();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                inc = 1'($urandom_range(0, 1));
                dec = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 15) == 0) sel = ~sel;
            tick_min = ($urandom_range(0, 3) == 0);
            load_en = ($urandom_range(0, 19) == 0);
            load_h = $urandom_range(0, 1) ? bcd($urandom_range(0, 23)) : 8'($urandom_range(0, 255));
            load_m = $urandom_range(0, 1) ? bcd($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
            rst = ($urandom_range(0, 99) == 0);
            cycle();
            checks++;
            if (hour !== bcd(mh) || minute !== bcd(mm)) begin
                errors++;
                $display("FAIL random_time cyc %0d got %h:%h want %h:%h", k, hour, minute, bcd(mh), bcd(mm));
            end
            checks++;
            if (editing !== m_act || load_err !== m_err) begin
                errors++;
                $display("FAIL random_flags cyc %0d got ed=%b err=%b want ed=%b err=%b", k, editing, load_err, m_act, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hour_wrap();
        test_auto_repeat();
        test_tick();
        test_load();
        test_conflicts();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
